// File: rtl/xy_mesh_router_param.sv
// 5-port XY mesh router node: per-input FIFOs, XY route on the FIFO head, per-output round-robin
// arbitration and registered outputs. Define XY_ROUTER_PKT_CNT_EN for per-output packet counters.
module xy_mesh_router_param #(
   parameter int WIDTH   = 32,
   parameter int ADDR_W  = 2,
   parameter int DEPTH   = 4,
   parameter int X_COORD = 0,
   parameter int Y_COORD = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5*WIDTH-1:0] in_data,
   input  logic [4:0]         in_valid,
   output logic [4:0]         in_ready,
   output logic [5*WIDTH-1:0] out_data,
   output logic [4:0]         out_valid,
   input  logic [4:0]         out_ready
`ifdef XY_ROUTER_PKT_CNT_EN
   ,
   input  logic               clr_cnt,
   output logic [5*16-1:0]    pkt_cnt
`endif
);
   localparam int NP    = 5;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [2:0] P_PE = 3'd0, P_N = 3'd1, P_S = 3'd2, P_E = 3'd3, P_W = 3'd4;

   logic [WIDTH-1:0] mem_q      [NP][DEPTH];
   logic [PTR_W-1:0] rd_ptr_q   [NP];
   logic [PTR_W-1:0] rd_ptr_d   [NP];
   logic [PTR_W-1:0] wr_ptr_q   [NP];
   logic [PTR_W-1:0] wr_ptr_d   [NP];
   logic [CNT_W-1:0] cnt_q      [NP];
   logic [CNT_W-1:0] cnt_d      [NP];
   logic [WIDTH-1:0] head       [NP];
   logic [2:0]       route      [NP];
   logic [NP-1:0]    head_vld;
   logic [NP-1:0]    push;
   logic [NP-1:0]    pop;
   logic [2:0]       last_q     [NP];
   logic [2:0]       last_d     [NP];
   logic [NP-1:0]    gnt_vld;
   logic [2:0]       gnt_idx    [NP];
   logic [WIDTH-1:0] out_data_q [NP];
   logic [WIDTH-1:0] out_data_d [NP];
   logic [NP-1:0]    out_valid_q;
   logic [NP-1:0]    out_valid_d;

   function automatic logic [2:0] xy_route(input logic [WIDTH-1:0] pkt);
      logic [ADDR_W-1:0] dx;
      logic [ADDR_W-1:0] dy;
      dx = pkt[WIDTH-1 -: ADDR_W];
      dy = pkt[WIDTH-1-ADDR_W -: ADDR_W];
      if (dx > ADDR_W'(X_COORD))      return P_E;
      else if (dx < ADDR_W'(X_COORD)) return P_W;
      else if (dy > ADDR_W'(Y_COORD)) return P_N;
      else if (dy < ADDR_W'(Y_COORD)) return P_S;
      else                            return P_PE;
   endfunction

   function automatic logic [2:0] rr_idx(input logic [2:0] base, input int unsigned off);
      int unsigned s;
      s = (32'(base) + off) % 5;
      return 3'(s);
   endfunction

   always_comb begin
      for (int p = 0; p < NP; p++) begin
         head_vld[p] = (cnt_q[p] != '0);
         head[p]     = mem_q[p][rd_ptr_q[p]];
         route[p]    = xy_route(head[p]);
      end
   end

   always_comb begin
      for (int p = 0; p < NP; p++) begin
         in_ready[p] = !reset && (cnt_q[p] != CNT_W'(DEPTH));
      end
   end

   assign push = in_valid & in_ready;

   // Search starts one past the last winner, so the last winner ends up lowest priority.
   always_comb begin
      logic [2:0] cand;
      cand = '0;
      for (int o = 0; o < NP; o++) begin
         gnt_vld[o] = 1'b0;
         gnt_idx[o] = last_q[o];
         if (!out_valid_q[o] || out_ready[o]) begin
            for (int i = 1; i <= NP; i++) begin
               cand = rr_idx(last_q[o], i);
               if (!gnt_vld[o] && head_vld[cand] && (route[cand] == 3'(o))) begin
                  gnt_vld[o] = 1'b1;
                  gnt_idx[o] = cand;
               end
            end
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int o = 0; o < NP; o++) begin
         if (gnt_vld[o]) pop[gnt_idx[o]] = 1'b1;
      end
   end

   always_comb begin
      for (int p = 0; p < NP; p++) begin
         rd_ptr_d[p] = rd_ptr_q[p] + PTR_W'(pop[p]);
         wr_ptr_d[p] = wr_ptr_q[p] + PTR_W'(push[p]);
         cnt_d[p]    = cnt_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
      end
      for (int o = 0; o < NP; o++) begin
         last_d[o]      = gnt_vld[o] ? gnt_idx[o] : last_q[o];
         out_valid_d[o] = gnt_vld[o] | (out_valid_q[o] & !out_ready[o]);
         out_data_d[o]  = gnt_vld[o] ? head[gnt_idx[o]] : out_data_q[o];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < NP; p++) begin
            rd_ptr_q[p]   <= '0;
            wr_ptr_q[p]   <= '0;
            cnt_q[p]      <= '0;
            last_q[p]     <= P_W;
            out_data_q[p] <= '0;
         end
         out_valid_q <= '0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            rd_ptr_q[p]   <= rd_ptr_d[p];
            wr_ptr_q[p]   <= wr_ptr_d[p];
            cnt_q[p]      <= cnt_d[p];
            last_q[p]     <= last_d[p];
            out_data_q[p] <= out_data_d[p];
         end
         out_valid_q <= out_valid_d;
      end
   end

   // Storage needs no reset: the cleared counts mark every entry as empty.
   always_ff @(posedge clk) begin
      for (int p = 0; p < NP; p++) begin
         if (push[p]) mem_q[p][wr_ptr_q[p]] <= in_data[p*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      for (int o = 0; o < NP; o++) begin
         out_data[o*WIDTH +: WIDTH] = out_data_q[o];
      end
   end

   assign out_valid = out_valid_q;

`ifdef XY_ROUTER_PKT_CNT_EN
   logic [15:0] pkt_cnt_q [NP];
   logic [15:0] pkt_cnt_d [NP];

   always_comb begin
      for (int o = 0; o < NP; o++) begin
         pkt_cnt_d[o] = pkt_cnt_q[o];
         if (clr_cnt)
            pkt_cnt_d[o] = '0;
         else if (out_valid_q[o] && out_ready[o] && (pkt_cnt_q[o] != 16'hFFFF))
            pkt_cnt_d[o] = pkt_cnt_q[o] + 16'd1;
         pkt_cnt[o*16 +: 16] = pkt_cnt_q[o];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int o = 0; o < NP; o++) pkt_cnt_q[o] <= '0;
      end else begin
         for (int o = 0; o < NP; o++) pkt_cnt_q[o] <= pkt_cnt_d[o];
      end
   end
`endif

endmodule

// File: tb/tb_xy_mesh_router_param.sv
// Bench for xy_mesh_router_param at (1,1): routing vector table, contention, backpressure,
// parallel forwarding, asynchronous reset and (with XY_ROUTER_PKT_CNT_EN) packet counters.
module tb_xy_mesh_router_param;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           reset;
   logic [5*W-1:0] in_data;
   logic [4:0]     in_valid;
   logic [4:0]     in_ready;
   logic [5*W-1:0] out_data;
   logic [4:0]     out_valid;
   logic [4:0]     out_ready;
`ifdef XY_ROUTER_PKT_CNT_EN
   logic           clr_cnt;
   logic [5*16-1:0] pkt_cnt;
`endif

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q [5][$];

   typedef struct packed {
      logic [2:0]   src;
      logic [W-1:0] data;
      logic [2:0]   port;
   } vec_t;
   vec_t vecs [8];

   always #5 clk = ~clk;

   xy_mesh_router_param #(
      .WIDTH(32), .ADDR_W(2), .DEPTH(4), .X_COORD(1), .Y_COORD(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready)
`ifdef XY_ROUTER_PKT_CNT_EN
      ,
      .clr_cnt(clr_cnt),
      .pkt_cnt(pkt_cnt)
`endif
   );

   task automatic chk(input string name, input logic [5*W-1:0] act, input logic [5*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int pending();
      return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() + exp_q[4].size();
   endfunction

   // Scoreboard: every output handshake must match the oldest expected packet for that port.
   always @(negedge clk) begin
      if (!reset) begin
         for (int o = 0; o < 5; o++) begin
            if (out_valid[o] && out_ready[o]) begin
               if (exp_q[o].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out[%0d]: got %h expected none", o, out_data[o*W +: W]);
               end else begin
                  chk($sformatf("out_data[%0d]", o), out_data[o*W +: W], exp_q[o].pop_front());
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      while (pending() != 0 && n < max_cyc) begin
         @(posedge clk);
         n++;
      end
      #2;
      checks++;
      if (pending() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", pending());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] pkt;
      vecs[0] = '{src:3'd0, data:32'hC000_00AA, port:3'd3};
      vecs[1] = '{src:3'd0, data:32'h4000_0011, port:3'd2};
      vecs[2] = '{src:3'd2, data:32'h6000_0022, port:3'd1};
      vecs[3] = '{src:3'd1, data:32'h0000_0033, port:3'd4};
      vecs[4] = '{src:3'd3, data:32'hF000_0044, port:3'd3};
      vecs[5] = '{src:3'd0, data:32'h5000_0055, port:3'd0};
      vecs[6] = '{src:3'd1, data:32'h2000_0066, port:3'd4};
      vecs[7] = '{src:3'd4, data:32'h5000_0001, port:3'd0};

      reset     = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 5'h1f;
`ifdef XY_ROUTER_PKT_CNT_EN
      clr_cnt   = 1'b0;
`endif
      #1;
      chk("in_ready_during_reset", 160'(in_ready), 160'd0);
      @(posedge clk); #1;
      chk("out_valid_reset", 160'(out_valid), 160'd0);
      chk("out_data_reset", out_data, 160'd0);
      tick();
      reset = 1'b0;
      #1;
      chk("in_ready_after_reset", 160'(in_ready), 160'h1f);
      tick();

      // Contention: all five inputs target the local PE; order PE,N,S,E,W twice.
      for (int b = 0; b < 2; b++) begin
         in_data = '0;
         for (int p = 0; p < 5; p++) begin
            pkt = 32'h5000_0000 | 32'(b << 8) | 32'(p);
            in_data[p*W +: W] = pkt;
            exp_q[0].push_back(pkt);
         end
         in_valid = 5'h1f;
         tick();
         in_valid = '0;
         @(negedge clk);
         chk("burst_latency", 160'(out_valid), 160'd0);
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("burst_valid", 160'(out_valid), 160'h01);
         end
         tick();
         drain(10);
      end

      // Single-packet routing table with exact latency.
      for (int i = 0; i < 8; i++) begin
         in_data = '0;
         in_data[32'(vecs[i].src)*W +: W] = vecs[i].data;
         in_valid = 5'b00001 << vecs[i].src;
         exp_q[vecs[i].port].push_back(vecs[i].data);
         chk("vec_in_ready", 160'(in_ready[vecs[i].src]), 160'd1);
         tick();
         in_valid = '0;
         @(negedge clk);
         chk($sformatf("vec%0d_early", i), 160'(out_valid), 160'd0);
         @(negedge clk);
         chk($sformatf("vec%0d_route", i), 160'(out_valid), 160'(5'b00001 << vecs[i].port));
         tick();
      end
      drain(10);

      // Backpressure on E: one packet in the output register, four in the PE FIFO.
      out_ready = 5'b10111;
      for (int i = 0; i < 5; i++) begin
         pkt = 32'hD000_0100 + 32'(i);
         in_data = '0;
         in_data[0 +: W] = pkt;
         in_valid = 5'b00001;
         chk("bp_in_ready", 160'(in_ready[0]), 160'd1);
         exp_q[3].push_back(pkt);
         tick();
      end
      in_valid = '0;
      @(negedge clk);
      chk("bp_full", 160'(in_ready[0]), 160'd0);
      chk("bp_out_valid", 160'(out_valid), 160'h08);
      chk("bp_out_data", 160'(out_data[3*W +: W]), 160'h D000_0100);
      tick();
      tick();
      @(negedge clk);
      chk("bp_hold_data", 160'(out_data[3*W +: W]), 160'h D000_0100);
      chk("bp_hold_ready", 160'(in_ready[0]), 160'd0);
      tick();
      out_ready = 5'h1f;
      drain(20);
      chk("bp_in_ready_after", 160'(in_ready), 160'h1f);

      // Parallel: E->W and W->E in the same cycle.
      in_data = '0;
      in_data[3*W +: W] = 32'h1000_0077;
      in_data[4*W +: W] = 32'hD000_0088;
      exp_q[4].push_back(32'h1000_0077);
      exp_q[3].push_back(32'hD000_0088);
      in_valid = 5'b11000;
      tick();
      in_valid = '0;
      @(negedge clk);
      @(negedge clk);
      chk("parallel_valid", 160'(out_valid), 160'h18);
      tick();
      drain(10);

      // Asynchronous reset with three packets buffered toward a stalled E.
      out_ready = '0;
      for (int i = 0; i < 3; i++) begin
         in_data = '0;
         in_data[0 +: W] = 32'hC000_0200 + 32'(i);
         in_valid = 5'b00001;
         tick();
      end
      in_valid = '0;
      tick();
      @(negedge clk);
      chk("rst_pre_valid", 160'(out_valid), 160'h08);
      #3;
      reset = 1'b1;
      #1;
      chk("rst_async_valid", 160'(out_valid), 160'd0);
      chk("rst_async_data", out_data, 160'd0);
      chk("rst_async_in_ready", 160'(in_ready), 160'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      out_ready = 5'h1f;
      #1;
      chk("rst_release_in_ready", 160'(in_ready), 160'h1f);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("rst_no_stale", 160'(out_valid), 160'd0);
      end
      tick();

`ifdef XY_ROUTER_PKT_CNT_EN
      for (int i = 0; i < 10; i++) begin
         pkt = 32'hC000_0300 + 32'(i);
         in_data = '0;
         in_data[0 +: W] = pkt;
         in_valid = 5'b00001;
         chk("cnt_in_ready", 160'(in_ready[0]), 160'd1);
         exp_q[3].push_back(pkt);
         tick();
      end
      in_valid = '0;
      drain(20);
      @(negedge clk);
      chk("pkt_cnt_e_10", 160'(pkt_cnt[3*16 +: 16]), 160'd10);
      tick();
      in_data = '0;
      in_data[0 +: W] = 32'hC000_0399;
      exp_q[3].push_back(32'hC000_0399);
      in_valid = 5'b00001;
      tick();
      in_valid = '0;
      tick();
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      @(negedge clk);
      chk("pkt_cnt_clr_wins", 160'(pkt_cnt[3*16 +: 16]), 160'd0);
      tick();
      drain(10);
`endif

      chk("final_empty", 160'(pending()), 160'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/xy_mesh_router_param.md
Name: xy_mesh_router_param

Overview:
- Synthesizable, clocked successor to the CSP-style XY router. One 5-port mesh router node: PE, N, S, E and W.
- Each input has a parametrised FIFO. Dimension-ordered XY routing compares header fields against the router's own coordinates.
- Each output has a round-robin arbiter and a registered output stage, all on valid/ready handshakes.
- Tiled in a MESH_X by MESH_Y array. Each router connects to neighbours' opposite ports and to its local PE.

Parameters:
- WIDTH, 32, packet width in bits.
- ADDR_W, 2, width of each coordinate field.
- DEPTH, 4, input FIFO depth per port; power of two, at least 2.
- X_COORD, 0, this router's x coordinate.
- Y_COORD, 0, this router's y coordinate.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  5*WIDTH  input packets; slice p is bits [p*WIDTH +: WIDTH]. Port index: 0=PE, 1=N, 2=S, 3=E, 4=W.
- in_valid  in  5  per-port input valid.
- in_ready  out  5  per-port input ready.
- out_data  out  5*WIDTH  output packets; same slicing as in_data.
- out_valid  out  5  per-port output valid.
- out_ready  in  5  per-port output ready.

Behaviour:
- Header fields: dst_x = pkt[WIDTH-1 -: ADDR_W]; dst_y = pkt[WIDTH-1-ADDR_W -: ADDR_W]. The remaining bits are payload.
- The packet is forwarded unmodified; no header rewrite.
- Route is computed from the FIFO head, in this order:
  - dst_x > X_COORD -> E.
  - dst_x < X_COORD -> W.
  - otherwise dst_y > Y_COORD -> N.
  - otherwise dst_y < Y_COORD -> S.
  - otherwise -> PE.
- Compares are unsigned, ADDR_W bits. No U-turn or off-mesh check.
- Edge routers may route off-mesh; integrators tie unused out_ready high.
- Input handshake:
  - Transfer when in_valid[p] & in_ready[p] at a rising edge.
  - in_ready[p] = !full[p], derived from the registered occupancy count.
  - A pop in the same cycle does not raise in_ready; a full FIFO stays not-ready that cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- FIFO: circular read/write pointers, wrap at DEPTH, occupancy count 0..DEPTH. Push while full is impossible by handshake.
- Output stage: one register per output holding out_data and out_valid.
  - The register may load when !out_valid[o] | out_ready[o].
  - out_data is held stable while out_valid & !out_ready.
- Arbitration: per output, a round-robin grant over the inputs whose head is routed to that output.
  - Priority starts at the index after the last granted input, wrapping 4 -> 0.
  - A grant happens only when the output stage can load. The granted FIFO pops on the same edge the output register loads.
  - One input can win at most one output per cycle, since each head has exactly one route.
  - Different outputs are granted independently and in parallel.
- Latency: a packet accepted on edge k to an empty FIFO with a free output shows out_valid from edge k+1.
- Throughput: one packet per output per cycle.
- Ordering: packets from the same input to the same output are never reordered.
- Reset (asynchronous, any time, including mid-transfer):
  - FIFOs emptied; pointers and counts cleared.
  - out_valid = 0 and out_data = 0.
  - in_ready = 1 while reset is deasserted and the FIFOs are empty. During reset in_ready is forced to 0.
  - Arbiter last-grant pointers = 4, so PE (index 0) has first priority.
  - In-flight packets are discarded.

Optional Feature:
- Macro XY_ROUTER_PKT_CNT_EN.
- When defined:
  - Adds output port pkt_cnt, 5*16 bits wide.
  - Counter o increments on each out_valid[o] & out_ready[o] handshake and saturates at 16'hFFFF.
  - All counters clear on reset.
  - Adds input clr_cnt, 1 bit, synchronous; it clears all counters and takes precedence over a same-cycle increment.
- When undefined: neither port exists and there is no counter logic. Routing behaviour is identical either way.

Test Plan:
- X=1,Y=1, WIDTH=32, ADDR_W=2, all out_ready=1. PE sends 32'hC000_00AA (dst 3,0) -> appears on E only, out_valid[3] the cycle after acceptance, data unchanged. W sends 32'h5000_0001 (dst 1,1) -> appears on PE.
- Contention: N, S, E, W and PE each send one packet to dst (1,1) in the same cycle -> PE output emits in order PE, N, S, E, W on consecutive cycles. A second identical burst is granted starting at PE again, confirming round-robin pointer wrap.
- Backpressure: out_ready[3]=0; PE sends 5 packets to dst (3,1) -> 4 in FIFO plus 1 in the output register, then in_ready[0]=0. Release out_ready -> all 5 emerge in original order with no loss or duplication.
- Parallel: E sends to dst (0,1) and W sends to dst (3,1) in the same cycle -> both forwarded, on W and E respectively, in the same cycle.
- Reset mid-operation: assert reset asynchronously with 3 packets buffered -> out_valid=0 immediately. After release, FIFOs are empty, in_ready=5'b11111, and no stale packet ever emerges.
- With XY_ROUTER_PKT_CNT_EN defined: send 10 packets to E -> pkt_cnt slice 3 reads 10. Pulse clr_cnt in the same cycle as an 11th handshake -> slice 3 reads 0.
